wb_traffic_gen: RTL
===================

# wb_traffic_gen

Synthesizable, self-checking Wishbone burst traffic generator that masters the SDRAM controller's Wishbone slave port in place of a behavioural stimulus driver. It is parametrised in data width, address width and burst length. It writes a deterministic pattern over a configurable region and reads it back, reporting the error count and the first failing address. It sits between a small control block (or the bench) and `sdrc_top`'s `wb_*` inputs, and gives hardware bring-up and regression the same traffic model.

## Interface
- `DW`, 32, Wishbone data width (32/16/8)
- `AW`, 26, Wishbone byte address width
- `BLW`, 5, burst-length field width; maximum burst is 2^BLW−1 beats
- `TIMEOUT`, 1024, cycles without `wb_ack_i` before a beat is aborted
- `wb_clk_i`  in  1  system clock; every flop is clocked on its rising edge
- `wb_rst_i`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; ignored while `busy`
- `cfg_mode`  in  2  00 write-only, 01 read-check-only, 10 write-then-read, 11 reserved (treated as 10)
- `cfg_base_addr`  in  AW  byte start address; the low log2(DW/8) bits are ignored
- `cfg_num_bursts`  in  16  number of bursts per pass; 0 means the pass is skipped
- `cfg_burst_len`  in  BLW  beats per burst; 0 is treated as 1
- `cfg_seed`  in  32  pattern seed
- `sdr_init_done`  in  1  controller initialisation complete
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master controls
- `wb_addr_o`  out  AW  byte address
- `wb_dat_o`  out  DW  write data
- `wb_sel_o`  out  DW/8  byte enables; always all ones
- `wb_cti_o`  out  3  cycle type
- `wb_ack_i`  in  1  slave acknowledge
- `wb_dat_i`  in  DW  read data
- `busy`, `done`, `err`  out  1  status
- `err_count`  out  16  number of mismatching read beats; saturates at 16'hFFFF
- `first_err_addr`  out  AW  address of the first mismatch

## Operation
- **States:**
  - `IDLE`, then on `start` to `WAIT_INIT`.
  - `WAIT_INIT` holds until `sdr_init_done`=1, then goes to `WR` (modes 00/10) or `RD` (mode 01).
  - `WR`/`RD` issue one burst. Each burst is followed by one `GAP` cycle with `cyc`=`stb`=0.
  - After the last write burst, mode 10 goes to `RD` and mode 00 goes to `FIN`.
  - After the last read burst, go to `FIN`.
  - `FIN` pulses nothing. It sets `done`=1 and `busy`=0, then returns to `IDLE`.
- **Configuration capture:** all `cfg_*` inputs are latched on an accepted `start`. Later changes have no effect until the next run.
- **Beat:** `cyc`/`stb` are held high until `wb_ack_i`. On ack, the address advances by DW/8 and the data is advanced. The address wraps modulo 2^AW.
- **Read pass:** restarts at `cfg_base_addr` with the pattern reseeded, so the expected data sequence equals the written sequence.
- **CTI:**
  - Multi-beat bursts use 3'b010 on every beat except the last, which uses 3'b111.
  - A 1-beat burst uses 3'b000.
- **Pattern (default):** the word at byte address A is `(A ^ cfg_seed)`, truncated or replicated to DW.
- **Check:** on each read ack, `wb_dat_i` is compared with the expected word.
  - On mismatch, `err_count` increments (saturating) and `err` goes to 1.
  - The first mismatch of a run loads `first_err_addr`.
- **Timeout:** if `TIMEOUT` cycles elapse in one beat with no ack:
  - drop `cyc`/`stb`;
  - set `err`=1;
  - set `first_err_addr` to the hung address if no earlier mismatch was recorded;
  - go to `FIN`.
- **Accepted start:** clears `done`, `err`, `err_count` and `first_err_addr`, and sets `busy`.
- **`start` while busy:** ignored, with no side effects.
- **Reset:** asserting `wb_rst_i`, including mid-burst, immediately forces the FSM to `IDLE` and all outputs to their reset values.

## Timing
- **Reset values:** every output is 0, except `wb_sel_o`, which is all ones.
- **Start to first beat:** `start` at cycle 0 gives `WAIT_INIT` at cycle 1. With `sdr_init_done`=1, `cyc`/`stb` assert at cycle 2.
- **Zero-wait slave:** ack in the same cycle as `stb` gives one beat per cycle.
- **Burst cost:** a burst of N beats with zero-wait ack occupies N+1 cycles, including `GAP`.
- **Error path:** the comparison is registered. `err`/`err_count` update 1 cycle after the offending ack. `done` is never asserted before the last comparison has landed.
- **Combinational path:** `wb_ack_i` reaches `wb_addr_o`/`wb_dat_o` only through flops. No combinational path exists from any input to any Wishbone output.

## Configuration
- **`WB_TG_LFSR_EN` defined:** the data comes from a 32-bit Galois LFSR, polynomial 0x80200003.
  - It is loaded with `cfg_seed` at the start of each pass and steps once per acked beat.
  - A seed of 0 is replaced by 32'h1.
- **`WB_TG_LFSR_EN` undefined:** the address-XOR pattern is used, and no LFSR flops are present.

## Structure
- **Package `wb_tg_pkg`:**
  - state enum
  - `cfg_mode` encodings
  - CTI constants: CLASSIC 3'b000, INCR 3'b010, EOB 3'b111
  - LFSR polynomial
- **Sub-module `wb_tg_pattern`:** a pattern generator with reseed, advance and address inputs and a DW output, instantiated once and shared by the write and read passes.

## Test plan
- Mode 10, base 0x100, 4 bursts × 8 beats, seed 0xA5A5A5A5, `sdrc_top` with 32-bit memory model → 32 writes then 32 reads; `done`=1, `err`=0, `err_count`=0.
- Same run with the model corrupting the word at 0x110 → `err_count`=1, `first_err_addr`=0x110, `err`=1.
- `cfg_burst_len`=1 → every beat has `cti`=3'b000; `cfg_burst_len`=31 → 30 beats of 3'b010 then one 3'b111.
- Slave never acks, `TIMEOUT`=16 → `cyc` drops after 16 cycles; `err`=1, `done`=1, `first_err_addr`=base.
- `wb_rst_i` pulsed mid-burst → next cycle `cyc`=`stb`=0 and `busy`=0; a new `start` reruns cleanly with no errors.
- Base 0x3FFFFF8, 4 beats, AW=26 → addresses 0x3FFFFF8, 0x3FFFFFC, 0x0, 0x4; readback passes.

Source files
------------

// File: rtl/wb_tg_pkg.sv
// ============================================================================
// Module   : wb_tg_pkg
// Purpose  : Shared types and constants for the Wishbone traffic generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_tg_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WR        = 3'd2,
        RD        = 3'd3,
        GAP       = 3'd4,
        FIN       = 3'd5
    } tg_state_t;

    localparam logic [1:0] c_MODE_WR_ONLY = 2'b00;
    localparam logic [1:0] c_MODE_RD_ONLY = 2'b01;
    localparam logic [1:0] c_MODE_WR_RD   = 2'b10;

    localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] c_CTI_INCR    = 3'b010;
    localparam logic [2:0] c_CTI_EOB     = 3'b111;

    localparam logic [31:0] c_LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois step; the polynomial mask is applied when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? c_LFSR_POLY : 32'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_tg_pattern.sv
// ============================================================================
// Module   : wb_tg_pattern
// Purpose  : Data pattern source shared by the write and read passes.
//            WB_TG_LFSR_EN selects a 32-bit Galois LFSR instead of addr^seed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_tg_pattern #(
    parameter int DW = 32,
    parameter int AW = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reseed,
    input  logic          advance,
    input  logic [31:0]   seed,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    import wb_tg_pkg::*;

    logic [31:0] w_word;
    logic        w_unused;

`ifdef WB_TG_LFSR_EN
    logic [31:0] r_lfsr;

    // A zero seed would lock the LFSR, so it is replaced by 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 32'h0;
        end else if (reseed) begin
            r_lfsr <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (advance) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign w_word   = r_lfsr;
    assign w_unused = ^addr;
`else
    assign w_word   = 32'(addr) ^ seed;
    assign w_unused = ^{clk, rst, reseed, advance};
`endif

    // Truncate or replicate the 32-bit word to the bus width.
    for (genvar i = 0; i < DW; i++) begin : g_bits
        assign data[i] = w_word[i % 32];
    end

endmodule

`default_nettype wire

// File: rtl/wb_traffic_gen.sv
// ============================================================================
// Module   : wb_traffic_gen
// Purpose  : Self-checking Wishbone burst master: writes a pattern over a
//            region, reads it back, counts mismatches. Option: WB_TG_LFSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_traffic_gen #(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int BLW     = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start,
    input  logic [1:0]      cfg_mode,
    input  logic [AW-1:0]   cfg_base_addr,
    input  logic [15:0]     cfg_num_bursts,
    input  logic [BLW-1:0]  cfg_burst_len,
    input  logic [31:0]     cfg_seed,
    input  logic            sdr_init_done,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [15:0]     err_count,
    output logic [AW-1:0]   first_err_addr
);
    import wb_tg_pkg::*;

    localparam int              c_BYTES    = DW / 8;
    localparam int              c_TW       = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   c_STEP     = AW'(c_BYTES);
    localparam logic [AW-1:0]   c_ALIGN    = ~AW'(c_BYTES - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    tg_state_t       r_state, w_next;

    logic [1:0]      r_mode;
    logic [AW-1:0]   r_base;
    logic [15:0]     r_num;
    logic [BLW-1:0]  r_len;
    logic [31:0]     r_seed;

    logic [AW-1:0]   r_addr;
    logic [BLW-1:0]  r_beat;
    logic [15:0]     r_burst;
    logic            r_pass_wr;
    logic [c_TW-1:0] r_tmo;

    logic            r_busy, r_done, r_err;
    logic [15:0]     r_err_count;
    logic [AW-1:0]   r_first_err_addr;
    logic            r_chk_vld, r_chk_mis;
    logic [AW-1:0]   r_chk_addr;

    logic            w_start_ok, w_last_beat, w_tmo, w_rd_after_wr;
    logic            w_active, w_we, w_pass_start, w_pass_wr;
    logic [2:0]      w_cti;
    logic [DW-1:0]   w_pat;

    assign w_start_ok    = start && !r_busy && (r_state == IDLE);
    assign w_last_beat   = (r_beat == r_len - BLW'(1));
    assign w_tmo         = !wb_ack_i && (r_tmo == c_TMO_LAST);
    assign w_rd_after_wr = (r_mode != c_MODE_WR_ONLY) && (r_mode != c_MODE_RD_ONLY);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pass_start = 1'b0;
        w_pass_wr    = 1'b0;
        w_active     = 1'b0;
        w_we         = 1'b0;
        w_cti        = c_CTI_CLASSIC;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_next = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (sdr_init_done) begin
                    w_pass_start = 1'b1;
                    w_pass_wr    = (r_mode != c_MODE_RD_ONLY);
                    if (r_num == 16'd0)              w_next = FIN;
                    else if (r_mode == c_MODE_RD_ONLY) w_next = RD;
                    else                             w_next = WR;
                end
            end
            WR, RD: begin
                w_active = 1'b1;
                w_we     = (r_state == WR);
                if (r_len != BLW'(1)) w_cti = w_last_beat ? c_CTI_EOB : c_CTI_INCR;
                if (w_tmo)                         w_next = FIN;
                else if (wb_ack_i && w_last_beat)  w_next = GAP;
            end
            GAP: begin
                if (r_burst == r_num) begin
                    if (r_pass_wr && w_rd_after_wr) begin
                        w_next       = RD;
                        w_pass_start = 1'b1;
                    end else begin
                        w_next = FIN;
                    end
                end else begin
                    w_next = r_pass_wr ? WR : RD;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Configuration capture and beat/burst bookkeeping.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_mode    <= 2'b00;
            r_base    <= '0;
            r_num     <= 16'd0;
            r_len     <= '0;
            r_seed    <= 32'h0;
            r_addr    <= '0;
            r_beat    <= '0;
            r_burst   <= 16'd0;
            r_pass_wr <= 1'b0;
            r_tmo     <= '0;
        end else begin
            if (w_start_ok) begin
                r_mode <= cfg_mode;
                r_base <= cfg_base_addr & c_ALIGN;
                r_num  <= cfg_num_bursts;
                r_len  <= (cfg_burst_len == '0) ? BLW'(1) : cfg_burst_len;
                r_seed <= cfg_seed;
            end
            if (w_pass_start) begin
                r_addr    <= r_base;
                r_beat    <= '0;
                r_burst   <= 16'd0;
                r_tmo     <= '0;
                r_pass_wr <= w_pass_wr;
            end else if (w_active) begin
                if (wb_ack_i) begin
                    r_addr <= r_addr + c_STEP;
                    r_tmo  <= '0;
                    if (w_last_beat) begin
                        r_beat  <= '0;
                        r_burst <= r_burst + 16'd1;
                    end else begin
                        r_beat <= r_beat + BLW'(1);
                    end
                end else begin
                    r_tmo <= r_tmo + c_TW'(1);
                end
            end
        end
    end

    // Status: the read comparison is registered, then folded into the error state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err            <= 1'b0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= '0;
            r_chk_vld        <= 1'b0;
            r_chk_mis        <= 1'b0;
            r_chk_addr       <= '0;
        end else begin
            r_chk_vld  <= w_active && wb_ack_i && !w_we;
            r_chk_mis  <= (wb_dat_i != w_pat);
            r_chk_addr <= r_addr;
            if (w_start_ok) begin
                r_busy           <= 1'b1;
                r_done           <= 1'b0;
                r_err            <= 1'b0;
                r_err_count      <= 16'd0;
                r_first_err_addr <= '0;
            end
            if (r_chk_vld && r_chk_mis) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                r_err <= 1'b1;
                if (!r_err) r_first_err_addr <= r_chk_addr;
            end
            if (w_active && w_tmo) begin
                r_err <= 1'b1;
                if (!r_err && !(r_chk_vld && r_chk_mis)) r_first_err_addr <= r_addr;
            end
            if (r_state == FIN) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    wb_tg_pattern #(
        .DW (DW),
        .AW (AW)
    ) u_pattern (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .reseed  (w_pass_start),
        .advance (w_active && wb_ack_i),
        .seed    (r_seed),
        .addr    (r_addr),
        .data    (w_pat)
    );

    assign wb_cyc_o       = w_active;
    assign wb_stb_o       = w_active;
    assign wb_we_o        = w_we;
    assign wb_addr_o      = r_addr;
    assign wb_dat_o       = w_pat;
    assign wb_sel_o       = '1;
    assign wb_cti_o       = w_cti;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

endmodule

`default_nettype wire
